// File: rtl/rect_scan_if.sv
// rect_scan_if: request/pixel bundle between a scan requester and rect_scan_gen
//   master drives start, fullScreen, xInit, yInit, width, height, ready, abort
//   slave  drives x, y, addr, valid, plot, busy, done
interface rect_scan_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int A_W = 15
);
    logic           start;
    logic           fullScreen;
    logic [X_W-1:0] xInit;
    logic [Y_W-1:0] yInit;
    logic [X_W-1:0] width;
    logic [Y_W-1:0] height;
    logic           ready;
    logic           abort;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [A_W-1:0] addr;
    logic           valid;
    logic           plot;
    logic           busy;
    logic           done;

    modport master (
        output start, fullScreen, xInit, yInit, width, height, ready, abort,
        input  x, y, addr, valid, plot, busy, done
    );

    modport slave (
        input  start, fullScreen, xInit, yInit, width, height, ready, abort,
        output x, y, addr, valid, plot, busy, done
    );
endinterface

// File: rtl/rect_scan_gen.sv
// rect_scan_gen: row-major pixel scanner over a rectangle or the full screen
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : rect_scan_if.slave -- start/fullScreen/xInit/yInit/width/height
//            request, ready/abort flow control, x/y/addr/valid/plot/busy/done out
module rect_scan_gen #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int A_W      = 15
) (
    input logic         clk,
    input logic         resetn,
    rect_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [X_W:0]   SW_WIDE = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SH_WIDE = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] SW_N    = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] SH_N    = Y_W'(SCREEN_H);

    state_t         state;
    logic [X_W-1:0] x0, w, col, ncol, sx0, sw, xr;
    logic [Y_W-1:0] y0, h, row, nrow, sy0, sh, yr;
    logic [X_W:0]   nx;
    logic [Y_W:0]   ny;
    logic [A_W-1:0] addr;
    logic           valid, plot, busy, done, last_col;

    // Parameters of a new request, with full-screen overriding the rectangle
    assign sx0 = bus.fullScreen ? '0 : bus.xInit;
    assign sy0 = bus.fullScreen ? '0 : bus.yInit;
    assign sw  = bus.fullScreen ? SW_N : bus.width;
    assign sh  = bus.fullScreen ? SH_N : bus.height;

    // Next scan position; coordinates are one bit wider so off-screen
    // pixels past the X_W/Y_W range are still recognised as clipped
    assign last_col = col == w - X_W'(1);
    assign ncol     = last_col ? '0 : col + X_W'(1);
    assign nrow     = last_col ? row + Y_W'(1) : row;
    assign nx       = {1'b0, x0} + {1'b0, ncol};
    assign ny       = {1'b0, y0} + {1'b0, nrow};

    function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
        return px < SW_WIDE && py < SH_WIDE;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            col   <= '0;
            row   <= '0;
            xr    <= '0;
            yr    <= '0;
            addr  <= '0;
            valid <= 1'b0;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    x0   <= sx0;
                    y0   <= sy0;
                    w    <= sw;
                    h    <= sh;
                    col  <= '0;
                    row  <= '0;
                    addr <= '0;
                    xr   <= sx0;
                    yr   <= sy0;
                    busy <= 1'b1;
                    if (sw != '0 && sh != '0) begin
                        state <= SCAN;
                        valid <= 1'b1;
                        plot  <= on_screen({1'b0, sx0}, {1'b0, sy0});
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                SCAN: if (bus.abort) begin
                    state <= IDLE;
                    valid <= 1'b0;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end else if (bus.ready) begin
                    if (last_col && row == h - Y_W'(1)) begin
                        state <= DONE;
                        valid <= 1'b0;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        col  <= ncol;
                        row  <= nrow;
                        xr   <= nx[X_W-1:0];
                        yr   <= ny[Y_W-1:0];
                        addr <= addr + A_W'(1);
                        plot <= on_screen(nx, ny);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x     = xr;
    assign bus.y     = yr;
    assign bus.addr  = addr;
    assign bus.valid = valid;
    assign bus.plot  = plot;
    assign bus.busy  = busy;
    assign bus.done  = done;
endmodule

// File: tb/tb_rect_scan_gen.sv
// tb_rect_scan_gen: table-driven and randomized checks of rect_scan_gen against a pixel-list model
module tb_rect_scan_gen;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    rect_scan_if bus ();
    rect_scan_gen dut (.clk(clk), .resetn(resetn), .bus(bus));

    int total = 0;
    int bad = 0;

    typedef struct {
        int x;
        int y;
        int addr;
        bit plot;
    } pix_t;

    typedef struct {
        bit fs;
        int xi;
        int yi;
        int w;
        int h;
        int pct;
        int n;
        int last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_x"}, bus.x, 0);
        chk({tag, "_y"}, bus.y, 0);
        chk({tag, "_addr"}, bus.addr, 0);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_plot"}, bus.plot, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    // Model: the full list of pixels a scan must emit, in row-major order
    task automatic run_scan(input bit fs, input int xi, input int yi, input int wi, input int hi,
                            input int pct, output int cnt, output int last);
        pix_t q[$];
        pix_t p;
        int x0, y0, w, h, idx, guard, limit;
        bit rdy, fin;
        x0 = fs ? 0 : xi;
        y0 = fs ? 0 : yi;
        w  = fs ? 160 : wi;
        h  = fs ? 120 : hi;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                p.x    = x0 + c;
                p.y    = y0 + r;
                p.addr = (r * w + c) % 32768;
                p.plot = (x0 + c < 160) && (y0 + r < 120);
                q.push_back(p);
            end
        bus.fullScreen = fs;
        bus.xInit  = 8'(xi);
        bus.yInit  = 7'(yi);
        bus.width  = 8'(wi);
        bus.height = 7'(hi);
        bus.ready  = 1'b1;
        bus.start  = 1'b1;
        tick;
        bus.start = 1'b0;
        idx = 0; cnt = 0; last = -1; fin = 0; guard = 0;
        limit = q.size() * 30 + 20;
        while (!fin) begin
            if (idx < q.size()) begin
                chk("valid", bus.valid, 1);
                chk("x", bus.x, q[idx].x & 255);
                chk("y", bus.y, q[idx].y & 127);
                chk("addr", bus.addr, q[idx].addr);
                chk("plot", bus.plot, q[idx].plot);
                chk("done_mid", bus.done, 0);
                chk("busy_mid", bus.busy, 1);
                rdy = $urandom_range(0, 99) < pct;
                bus.ready = rdy;
                tick;
                if (rdy) begin
                    cnt++;
                    last = q[idx].addr;
                    idx++;
                end
            end else begin
                chk("done_pulse", bus.done, 1);
                chk("valid_end", bus.valid, 0);
                tick;
                chk("done_once", bus.done, 0);
                chk("busy_end", bus.busy, 0);
                fin = 1;
            end
            guard++;
            if (guard > limit) begin
                chk("timeout", 0, 1);
                fin = 1;
            end
        end
        bus.ready = 1'b1;
    endtask

    vec_t vecs[$];
    int cnt, last;

    initial begin
        bus.start = 0; bus.fullScreen = 0; bus.xInit = 0; bus.yInit = 0;
        bus.width = 0; bus.height = 0; bus.ready = 1; bus.abort = 0;

        #2 resetn = 1'b0;
        #1 check_idle_zero("reset");
        tick;
        tick;
        resetn = 1'b1;

        vecs.push_back('{0, 10, 20, 3, 2, 100, 6, 5});
        vecs.push_back('{0, 158, 0, 4, 1, 100, 4, 3});
        vecs.push_back('{0, 0, 0, 0, 5, 100, 0, -1});
        vecs.push_back('{0, 0, 0, 4, 0, 100, 0, -1});
        vecs.push_back('{0, 5, 5, 7, 3, 60, 21, 20});
        vecs.push_back('{0, 250, 126, 10, 3, 50, 30, 29});
        vecs.push_back('{1, 77, 33, 0, 0, 100, 19200, 19199});
        vecs.push_back('{0, 0, 0, 255, 127, 100, 32385, 32384});
        vecs.push_back('{0, 3, 1, 2, 3, 50, 6, 5});

        foreach (vecs[i]) begin
            run_scan(vecs[i].fs, vecs[i].xi, vecs[i].yi, vecs[i].w, vecs[i].h, vecs[i].pct, cnt, last);
            chk("vec_count", cnt, vecs[i].n);
            chk("vec_last_addr", last, vecs[i].last);
        end

        for (int i = 0; i < 8; i++)
            run_scan(0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 12),
                     $urandom_range(0, 6), $urandom_range(40, 100), cnt, last);

        // abort on the third pixel; a second start mid-scan must be ignored
        bus.fullScreen = 0; bus.xInit = 30; bus.yInit = 40; bus.width = 5; bus.height = 2;
        bus.ready = 1; bus.start = 1;
        tick;
        bus.start = 0;
        chk("ab_x0", bus.x, 30);
        bus.start = 1; bus.xInit = 99; bus.width = 1;
        tick;
        bus.start = 0;
        chk("ab_x1", bus.x, 31);
        tick;
        chk("ab_x2", bus.x, 32);
        chk("ab_addr2", bus.addr, 2);
        bus.abort = 1;
        tick;
        bus.abort = 0;
        chk("ab_valid", bus.valid, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_done", bus.done, 0);
        run_scan(0, 1, 2, 3, 1, 100, cnt, last);
        chk("ab_restart_cnt", cnt, 3);

        // reset in the middle of a scan clears outputs without waiting for a clock
        bus.xInit = 3; bus.yInit = 3; bus.width = 10; bus.height = 10; bus.start = 1;
        tick;
        bus.start = 0;
        tick;
        tick;
        chk("rst_mid_valid", bus.valid, 1);
        chk("rst_mid_addr", bus.addr, 2);
        resetn = 1'b0;
        #1 check_idle_zero("rst_mid");
        tick;
        resetn = 1'b1;
        run_scan(0, 100, 50, 2, 2, 100, cnt, last);
        chk("post_rst_cnt", cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
